// File: rtl/dft_sequencer.sv
// dft_sequencer: central controller for the direct-DFT MAC datapath.
// Waits for the sample RAM to be loaded, copies it into the cache, then runs
// the k/n double loop driving accumulator clear/enable and result write-back.
module dft_sequencer #(
    parameter int IDX_W   = 12,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mac_mode,
    input  logic [IDX_W-1:0] sample_num,
    input  logic             data_loaded,
    output logic             load_to_cache,
    output logic             ram_mode,
    output logic [IDX_W-1:0] cache_addr,
    output logic [IDX_W-1:0] k_idx,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_addr,
    input  logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_LOAD  = 3'd1;
    localparam logic [2:0] S_CACHE_FILL = 3'd2;
    localparam logic [2:0] S_COMPUTE    = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;
    localparam logic [2:0] S_WRITE      = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    // Drain counter runs 0..MAC_LAT-1.
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    logic [2:0]         r_state;
    logic [IDX_W-1:0]   r_n;
    logic [IDX_W-1:0]   r_cache_addr;
    logic [IDX_W-1:0]   r_k_idx;
    logic [MAC_LAT-1:0] r_pipe;
    logic [DW-1:0]      r_drain;
    logic               r_err;

    logic [IDX_W-1:0]   w_last;
    logic               w_issue;
    logic               w_start_req;

    // Highest valid index for the latched N; N>=2 guarantees no underflow.
    assign w_last      = r_n - 1'b1;
    // Every COMPUTE cycle issues one cache read / twiddle lookup.
    assign w_issue     = (r_state == S_COMPUTE);
    assign w_start_req = start && mac_mode;

    // Main sequencer: state, N latch, n/k indices, drain timer and err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_cache_addr <= '0;
            r_k_idx      <= '0;
            r_drain      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_req) begin
                        if (sample_num >= IDX_W'(2)) begin
                            r_n     <= sample_num;
                            r_state <= S_WAIT_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (data_loaded) begin
                        r_cache_addr <= '0;
                        r_state      <= S_CACHE_FILL;
                    end
                end
                S_CACHE_FILL: begin
                    if (r_cache_addr == w_last) begin
                        r_cache_addr <= '0;
                        r_k_idx      <= '0;
                        r_state      <= S_COMPUTE;
                    end else begin
                        r_cache_addr <= r_cache_addr + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    // Address parks at N-1 once the last sample is issued.
                    if (r_cache_addr == w_last) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cache_addr <= r_cache_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DW'(MAC_LAT - 1)) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (res_ready) begin
                        if (r_k_idx == w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_k_idx      <= r_k_idx + 1'b1;
                            r_cache_addr <= '0;
                            r_state      <= S_COMPUTE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Issue strobe delayed MAC_LAT cycles to line acc_en up with the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < MAC_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign state         = r_state;
    assign busy          = (r_state != S_IDLE);
    assign ram_mode      = (r_state == S_IDLE) || (r_state == S_WAIT_LOAD) ||
                           (r_state == S_CACHE_FILL);
    assign load_to_cache = (r_state == S_CACHE_FILL);
    assign cache_addr    = r_cache_addr;
    assign k_idx         = r_k_idx;
    assign acc_clear     = (r_state == S_COMPUTE) && (r_cache_addr == '0);
    assign acc_en        = r_pipe[MAC_LAT-1];
    assign res_valid     = (r_state == S_WRITE);
    assign res_addr      = r_k_idx;
    assign done          = (r_state == S_DONE);
    assign err           = r_err;

endmodule

// File: tb/tb_dft_sequencer.sv
// Testbench for dft_sequencer: IDLE/start vector table, full-run sequences
// with stalls, mid-run reset and randomized runs against a per-cycle
// expectation derived from the pass/phase timing rules.
module tb_dft_sequencer;

    localparam int IW = 12;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst, start, mac_mode, data_loaded, res_ready;
    logic [IW-1:0] sample_num;
    logic          load_to_cache, ram_mode, acc_clear, acc_en, res_valid;
    logic          busy, done, err;
    logic [IW-1:0] cache_addr, k_idx, res_addr;
    logic [2:0]    state;

    int nvec = 0;
    int nerr = 0;

    dft_sequencer #(.IDX_W(IW), .MAC_LAT(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .mac_mode(mac_mode),
        .sample_num(sample_num), .data_loaded(data_loaded),
        .load_to_cache(load_to_cache), .ram_mode(ram_mode),
        .cache_addr(cache_addr), .k_idx(k_idx), .acc_clear(acc_clear),
        .acc_en(acc_en), .res_valid(res_valid), .res_addr(res_addr),
        .res_ready(res_ready), .busy(busy), .done(done), .err(err),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Flags bundle: state, busy, ram_mode, load, clear, en, valid, done, err.
    task automatic expect_cyc(input string tag, input int st, input bit ld, input bit clr,
                              input bit en, input bit vld, input bit dn,
                              input int ca, input int kk);
        logic [10:0] e, a;
        e = {3'(st), (st != 0), (st <= 2), ld, clr, en, vld, dn, 1'b0};
        a = {state, busy, ram_mode, load_to_cache, acc_clear, acc_en, res_valid, done, err};
        cmp({tag, " flags"}, 32'(a), 32'(e));
        if (ca >= 0) cmp({tag, " cache_addr"}, 32'(cache_addr), 32'(ca));
        if (kk >= 0) cmp({tag, " k_idx"}, 32'(k_idx), 32'(kk));
        if (vld) cmp({tag, " res_addr"}, 32'(res_addr), 32'(kk));
    endtask

    task automatic check_reset(input string tag);
        logic [44:0] a, e;
        a = {load_to_cache, ram_mode, cache_addr, k_idx, acc_clear, acc_en,
             res_valid, res_addr, busy, done, err, state};
        e = {1'b0, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        cmp(tag, 32'(a ^ e), 32'd0);
    endtask

    // Disturb the inputs that must be ignored while busy.
    task automatic junk();
        start      = 1'($urandom);
        mac_mode   = 1'($urandom);
        sample_num = IW'($urandom);
    endtask

    // One full operation from IDLE. stall_k/stall_len hold res_ready low on
    // one bin; rnd makes res_ready random; abort_k/abort_n fire rst in COMPUTE.
    task automatic run(input int n, input int wait_c, input int stall_k, input int stall_len,
                       input bit rnd, input int abort_k, input int abort_n);
        int cyc;
        int cnt;
        bit rdy;
        cyc = 0;
        start = 1'b1; mac_mode = 1'b1; sample_num = IW'(n);
        data_loaded = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        for (int w = 0; w <= wait_c; w++) begin
            expect_cyc("wait_load", 1, 0, 0, 0, 0, 0, -1, -1);
            junk();
            data_loaded = (w == wait_c);
            @(negedge clk);
        end
        for (int a = 0; a < n; a++) begin
            cyc++;
            expect_cyc("cache_fill", 2, 1, 0, 0, 0, 0, a, -1);
            junk();
            data_loaded = 1'($urandom);
            @(negedge clk);
        end
        for (int k = 0; k < n; k++) begin
            // One pass: N issue cycles then MAC_LAT drain cycles; the product
            // of the issue at pass cycle c lands at cycle c+MAC_LAT.
            for (int c = 0; c < n + ML; c++) begin
                cyc++;
                expect_cyc(c < n ? "compute" : "drain", c < n ? 3 : 4, 0, c == 0,
                           (c >= ML), 0, 0, c < n ? c : -1, k);
                if (k == abort_k && c == abort_n) begin
                    rst = 1'b1; start = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    check_reset("abort reset");
                    @(negedge clk);
                    check_reset("abort idle");
                    return;
                end
                junk();
                res_ready = 1'($urandom);
                @(negedge clk);
            end
            cnt = 0;
            rdy = 1'b0;
            while (!rdy && cnt < 40) begin
                cyc++;
                expect_cyc("write", 5, 0, 0, 0, 1, 0, -1, k);
                if (rnd) rdy = ($urandom_range(0, 2) != 0) || (cnt >= 6);
                else     rdy = (k == stall_k) ? (cnt >= stall_len) : 1'b1;
                junk();
                res_ready = rdy;
                @(negedge clk);
                cnt++;
            end
            if (k == stall_k) cmp("stall valid cycles", 32'(cnt), 32'(stall_len + 1));
        end
        cyc++;
        expect_cyc("done", 6, 0, 0, 0, 0, 1, -1, -1);
        if (!rnd && stall_k < 0) cmp("done cycle index", 32'(cyc), 32'(n + n * (n + ML + 1) + 1));
        junk();
        @(negedge clk);
        start = 1'b0;
        expect_cyc("idle after done", 0, 0, 0, 0, 0, 0, -1, -1);
    endtask

    typedef struct {
        bit            rst;
        bit            start;
        bit            mm;
        logic [IW-1:0] num;
        logic [2:0]    st;
        bit            err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 12'd0, 3'd0, 1'b0};  // reset
        tbl[1] = '{1'b0, 1'b1, 1'b1, 12'd1, 3'd0, 1'b1};  // N=1 rejected
        tbl[2] = '{1'b0, 1'b0, 1'b1, 12'd1, 3'd0, 1'b0};  // err is one cycle
        tbl[3] = '{1'b0, 1'b1, 1'b1, 12'd0, 3'd0, 1'b1};  // N=0 rejected
        tbl[4] = '{1'b0, 1'b1, 1'b0, 12'd5, 3'd0, 1'b0};  // mac_mode=0 ignored
        tbl[5] = '{1'b0, 1'b1, 1'b1, 12'd2, 3'd1, 1'b0};  // N=2 accepted
        tbl[6] = '{1'b0, 1'b1, 1'b1, 12'd1, 3'd1, 1'b0};  // start while busy ignored
        tbl[7] = '{1'b1, 1'b1, 1'b1, 12'd3, 3'd0, 1'b0};  // reset wins
        tbl[8] = '{1'b0, 1'b1, 1'b0, 12'd0, 3'd0, 1'b0};  // mac_mode=0, no err

        rst = 1'b1; start = 1'b0; mac_mode = 1'b0; sample_num = '0;
        data_loaded = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset state");

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; mac_mode = tbl[i].mm;
            sample_num = tbl[i].num;
            @(negedge clk);
            cmp($sformatf("table[%0d] state/err/busy/ram_mode", i),
                32'({state, err, busy, ram_mode}),
                32'({tbl[i].st, tbl[i].err, (tbl[i].st != 3'd0), (tbl[i].st <= 3'd2)}));
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_reset("idle after table");

        // N=4, data_loaded and res_ready effectively tied high.
        run(4, 0, -1, 0, 1'b0, -1, -1);
        // res_ready held low 5 cycles on k=1.
        run(4, 1, 1, 5, 1'b0, -1, -1);
        // Reset during COMPUTE at k=2, n=1, then a clean run.
        run(4, 2, -1, 0, 1'b0, 2, 1);
        run(4, 0, -1, 0, 1'b0, -1, -1);
        // Smallest legal N.
        run(2, 0, -1, 0, 1'b0, -1, -1);
        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            run($urandom_range(2, 9), $urandom_range(0, 3), -1, 0, 1'b1, -1, -1);
        end
        // Maximum N: full cache fill, first pass and write, then abort at k=1.
        run(4095, 0, -1, 0, 1'b0, 1, 0);
        run(3, 1, -1, 0, 1'b1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
